multi_seven_seg: RTL

Parametrised N-digit multiplexed seven-segment driver. It is the successor to the fixed four-digit driver. It adds:
- a configurable digit count and refresh rate
- per-digit blanking
- leading-zero suppression
- PWM brightness control
- double-buffered (shadow) digit values

It sits between the datapath/register bank and the board's anode/cathode pins.

---
 rtl/multi_seven_seg.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/multi_seven_seg.sv
// Purpose: N-digit multiplexed seven-segment driver with shadowed digit data, blanking, leading-zero suppression and PWM dimming.
// Latency: an/seg are registered one cycle after the scan state; shadow loads show on the output one cycle after capture.
// Backpressure: none; free-running scan, inputs are sampled only on load (bright is sampled live).
module multi_seven_seg #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int BRIGHT_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   vals,
    input  logic [DIGITS-1:0]     dots,
    input  logic [DIGITS-1:0]     blank,
    input  logic                  lz_en,
    input  logic [BRIGHT_W-1:0]   bright,
    input  logic                  load,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            seg,
    output logic                  frame_tick
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    // Wide enough for (bright+1) * REFRESH_DIV without overflow.
    localparam int PW = CW + BRIGHT_W + 2;

    logic [4*DIGITS-1:0] sh_vals;
    logic [DIGITS-1:0]   sh_dots;
    logic [DIGITS-1:0]   sh_blank;
    logic                sh_lz;

    logic [CW-1:0]       slot_cnt;
    logic [IW-1:0]       idx;
    logic                slot_last;
    logic                idx_last;

    logic [PW-1:0]       on_cycles;
    logic                pwm_on;

    logic [DIGITS-1:0]   supp;
    logic                all_zero;
    logic [3:0]          cur_nib;
    logic                cur_dot;
    logic                cur_blank;
    logic                cur_supp;
    logic [DIGITS-1:0]   an_nxt;
    logic [7:0]          seg_nxt;

    // Active-low gfedcba pattern for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    // Shadow capture: the display only ever reads these copies.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_vals  <= '0;
            sh_dots  <= '0;
            sh_blank <= '0;
            sh_lz    <= 1'b0;
        end else if (load) begin
            sh_vals  <= vals;
            sh_dots  <= dots;
            sh_blank <= blank;
            sh_lz    <= lz_en;
        end
    end

    assign slot_last = (slot_cnt == CW'(REFRESH_DIV - 1));
    assign idx_last  = (idx == IW'(DIGITS - 1));

    // Slot counter and digit index; frame_tick marks the index wrapping back to digit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt   <= '0;
            idx        <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= slot_last && idx_last;
            if (slot_last) begin
                slot_cnt <= '0;
                idx      <= idx_last ? '0 : idx + 1'b1;
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end
        end
    end

    // Anode on-time within a slot; all-ones brightness yields exactly REFRESH_DIV.
    assign on_cycles = ((PW'(bright) + PW'(1)) * PW'(REFRESH_DIV)) >> BRIGHT_W;
    assign pwm_on    = ({{(PW - CW){1'b0}}, slot_cnt} < on_cycles);

    // Suppression mask: a digit is dark when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        supp     = '0;
        all_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero & (sh_vals[4*i +: 4] == 4'h0);
            supp[i]  = sh_lz & all_zero & (i != 0);
        end
    end

    // Select the active digit's data and build the next anode/cathode pattern.
    always_comb begin
        cur_nib   = 4'h0;
        cur_dot   = 1'b0;
        cur_blank = 1'b0;
        cur_supp  = 1'b0;
        an_nxt    = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_nib   = sh_vals[4*i +: 4];
                cur_dot   = sh_dots[i];
                cur_blank = sh_blank[i];
                cur_supp  = supp[i];
            end
        end
        for (int i = 0; i < DIGITS; i++) begin
            an_nxt[i] = !((idx == IW'(i)) && pwm_on && !cur_blank);
        end
        seg_nxt = {~cur_dot, cur_supp ? 7'h7F : hex7(cur_nib)};
    end

    // Register an and seg together so digit switches never bleed into each other.
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= '1;
            seg <= 8'hFF;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
        end
    end

endmodule
